// File: rtl/multdiv_seq_pkg.sv
// Shared CPU definitions: multdiv FSM encoding, datapath step commands and
// the opcodes that DX decode and the stall unit key off.
package multdiv_seq_pkg;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;
  localparam logic [4:0] OP_LW  = 5'b01000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'd0,
    CMD_LD_MUL = 2'd1,
    CMD_LD_DIV = 2'd2,
    CMD_STEP   = 2'd3
  } step_cmd_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Booth multiply / restoring divide datapath. One step per CMD_STEP; the final
// result is presented from next-state values so the FSM can latch it on the
// edge that enters DONE.
import multdiv_seq_pkg::*;

module multdiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  step_cmd_e        cmd,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             div0,
  output logic [WIDTH-1:0] fin_result,
  output logic             fin_exc
);

  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d, m_q, m_d;
  logic             qm1_q, qm1_d, is_div_q, is_div_d, neg_q, neg_d;
  logic             div0_q, div0_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   booth_sum, r_sh, diff;

  always_comb begin
    mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    // hi carries one guard bit so subtracting the most negative multiplier cannot overflow
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = hi_q - {m_q[WIDTH-1], m_q};
      default: booth_sum = hi_q;
    endcase

    r_sh = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    diff = r_sh - {1'b0, m_q};

    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;

    case (cmd)
      CMD_LD_MUL: begin
        hi_d     = '0;
        lo_d     = op_a;
        qm1_d    = 1'b0;
        m_d      = op_b;
        is_div_d = 1'b0;
        neg_d    = 1'b0;
        div0_d   = 1'b0;
        ovf_d    = 1'b0;
      end
      CMD_LD_DIV: begin
        hi_d     = '0;
        lo_d     = mag_a;
        qm1_d    = 1'b0;
        m_d      = mag_b;
        is_div_d = 1'b1;
        neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        div0_d   = (op_b == '0);
        ovf_d    = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
      end
      CMD_STEP: begin
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            hi_d = diff;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = r_sh;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d, qm1_d} = {booth_sum[WIDTH], booth_sum, lo_q};
        end
      end
      default: ;
    endcase

    if (is_div_d) begin
      fin_result = div0_d ? '0 : (neg_d ? -lo_d : lo_d);
      fin_exc    = div0_d | ovf_d;
    end else begin
      fin_result = lo_d;
      fin_exc    = (hi_d[WIDTH-1:0] != {WIDTH{lo_d[WIDTH-1]}});
    end
  end

  assign div0 = div0_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit: FSM, iteration counter and the
// start/stall/result handshake around multdiv_datapath.
import multdiv_seq_pkg::*;

module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_rd,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [4:0]       result_rd
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d, result_rd_q, result_rd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  step_cmd_e        cmd;
  logic             dp_div0, dp_exc;
  logic [WIDTH-1:0] dp_result;

  multdiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd        (cmd),
    .op_a       (operand_a),
    .op_b       (operand_b),
    .div0       (dp_div0),
    .fin_result (dp_result),
    .fin_exc    (dp_exc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    result_d    = result_q;
    exc_d       = exc_q;
    result_rd_d = result_rd_q;
    cmd         = CMD_HOLD;

    case (state_q)
      IDLE: begin
        if (!cancel && ctrl_mult) begin
          state_d = MULT;
          cnt_d   = '0;
          rd_d    = dest_rd;
          cmd     = CMD_LD_MUL;
        end else if (!cancel && ctrl_div) begin
          state_d = DIV;
          cnt_d   = '0;
          rd_d    = dest_rd;
          cmd     = CMD_LD_DIV;
        end
      end
      MULT, DIV: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (state_q == DIV && dp_div0) begin
          // zero divisor skips the iterations entirely
          state_d     = DONE;
          cnt_d       = '0;
          result_d    = dp_result;
          exc_d       = dp_exc;
          result_rd_d = rd_q;
        end else begin
          cmd = CMD_STEP;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d     = DONE;
            cnt_d       = '0;
            result_d    = dp_result;
            exc_d       = dp_exc;
            result_rd_d = rd_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      result_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      result_rd_q <= result_rd_d;
    end
  end

  // start-cycle term lets the stall unit freeze DX in the same cycle
  assign busy       = (state_q == MULT) || (state_q == DIV) ||
                      ((state_q == IDLE) && !cancel && (ctrl_mult || ctrl_div));
  assign result_rdy = (state_q == DONE) && !cancel;
  assign result     = result_q;
  assign exception  = exc_q;
  assign result_rd  = result_rd_q;

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
Iterative signed 32-bit multiply/divide unit fed from the DX stage. It accepts one MUL or DIV per start pulse and computes one iteration per clock. It drives `busy` into the stall unit's `mult_operation` input, so the pipeline freezes while an operation is in flight. It then delivers a one-cycle result strobe, with a destination-register tag, to XM writeback.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ctrl_mult  in  1  start-multiply pulse, sampled when idle
ctrl_div  in  1  start-divide pulse, sampled when idle
cancel  in  1  abort the in-flight operation (branch flush)
operand_a  in  WIDTH  multiplicand / dividend, signed two's complement
operand_b  in  WIDTH  multiplier / divisor, signed two's complement
dest_rd  in  5  destination register tag, latched at start
busy  out  1  operation in progress; goes to stall `mult_operation`
result_rdy  out  1  one-cycle result-valid strobe
result  out  WIDTH  product low word or quotient
exception  out  1  overflow / divide-by-zero flag, valid with result_rdy
result_rd  out  5  latched dest_rd, valid with result_rdy

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE and the counter clears.
  - busy=0, result_rdy=0, result=0, exception=0, result_rd=0.
  - Reset mid-operation discards all work; no result_rdy is produced afterwards.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - ctrl_mult=1 latches operands and dest_rd, then goes to MULT with count=0.
  - ctrl_div=1 (with ctrl_mult=0) does the same and goes to DIV.
  - If both starts are high, ctrl_mult wins.
- busy:
  - busy = (state is MULT or DIV) OR (state is IDLE AND (ctrl_mult OR ctrl_div)).
  - The combinational term stalls the pipeline in the start cycle itself.
  - busy=0 in DONE.
- Starts outside IDLE are ignored, including in DONE. A start is accepted on the next cycle after DONE.
- MULT:
  - Radix-2 Booth. Accumulator {A[WIDTH-1:0], Q[WIDTH-1:0], q_-1}, one add/sub plus arithmetic shift per cycle.
  - After WIDTH iterations (count==WIDTH-1 at the edge) go to DONE.
  - result = Q (low word).
  - exception=1 iff A is not all copies of Q[WIDTH-1], i.e. the product does not fit in WIDTH signed bits.
- DIV:
  - Operands are converted to magnitudes at start. The quotient sign is the XOR of the operand signs.
  - Unsigned restoring division, one quotient bit per cycle, WIDTH cycles, then DONE.
  - The quotient is negated if the sign is 1. The remainder is discarded.
  - Divisor==0: the iterations are skipped and the unit goes from DIV to DONE on the next edge with result=0, exception=1.
  - Dividend==-2^(WIDTH-1) with divisor==-1: result=0x8000_0000, exception=1.
- DONE:
  - result_rdy=1, with result, exception and result_rd stable for exactly this cycle.
  - Next edge returns to IDLE.
  - result, exception and result_rd hold their values until the next DONE; result_rdy returns to 0.
- Latency:
  - Start in cycle 0 gives result_rdy in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - Divide-by-zero gives result_rdy in cycle 2.
- cancel:
  - In MULT/DIV: next edge goes to IDLE with no result_rdy. busy stays 1 in the cancel cycle.
  - In DONE: result_rdy is suppressed (forced to 0) that cycle.
  - In IDLE with a start: the start is ignored and busy=0.
- The counter wraps only by returning to IDLE. It never exceeds WIDTH-1.

Decomposition:
- A shared CPU package holds:
  - the state encoding localparams (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3);
  - ALU opcode constants OP_MUL=5'b00110 and OP_DIV=5'b00111, used by the DX decode that generates ctrl_mult and ctrl_div;
  - the LW opcode constant shared with the stall unit.
- One sub-module, `multdiv_datapath`, holds the shift registers, adder/subtractor and sign fix-up, and takes a 2-bit step command from the FSM.
- The FSM, counter and handshake stay in multdiv_seq.

Test Plan:
- MUL 7 x 6 at cycle 0 -> busy=1 in cycles 0..32; result_rdy in cycle 33 with result=42, exception=0, result_rd=dest_rd.
- MUL -3 x 5 -> result=0xFFFF_FFF1, exception=0. MUL 0x0001_0000 x 0x0001_0000 -> result=0, exception=1.
- DIV 100 / -7 -> result=0xFFFF_FFF2 (-14), exception=0. DIV 0x8000_0000 / -1 -> result=0x8000_0000, exception=1.
- DIV 5 / 0 -> result_rdy in cycle 2 with result=0, exception=1; busy=0 from cycle 2.
- ctrl_div pulsed in cycle 10 of a MUL -> ignored, MUL result unchanged. Both starts high in IDLE -> MULT is taken.
- cancel in cycle 15 -> IDLE at cycle 16, no result_rdy. reset_n low in cycle 20 of a DIV -> all outputs 0 immediately, no strobe after release.
